// File: rtl/image_loader_if.sv
// Byte-stream, RAM write port and status signals of the image loader.
// The loader connects as slave; the UART side, RAM and inference controller connect as master.
interface image_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              clear;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [7:0]        ram_wr_data;
  logic              ram_wr_en;
  logic              image_ready;
  logic              busy;
  logic              load_err;

  modport slave (
    input  rx_valid, rx_data, clear,
    output ram_wr_addr, ram_wr_data, ram_wr_en, image_ready, busy, load_err
  );

  modport master (
    output rx_valid, rx_data, clear,
    input  ram_wr_addr, ram_wr_data, ram_wr_en, image_ready, busy, load_err
  );
endinterface

// File: rtl/image_loader.sv
// Frames a UART byte stream (HDR0 HDR1 + NUM_PIXELS pixels) into the image RAM.
// Define IMAGE_LOADER_CHECKSUM_EN to require a trailing mod-256 pixel sum byte.
module image_loader #(
  parameter int          NUM_PIXELS     = 784,
  parameter int          ADDR_W         = 10,
  parameter logic [7:0]  HDR0           = 8'hAA,
  parameter logic [7:0]  HDR1           = 8'h55,
  parameter int          TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst,
  image_loader_if.slave bus
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef IMAGE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR1_WAIT, LOAD, CHK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR1_WAIT, LOAD, DONE} state_t;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              err_q, err_d;
  logic              busy_w;
`ifdef IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  assign busy_w = (state_q == HDR1_WAIT) || (state_q == LOAD) || (state_q == CHK);
`else
  assign busy_w = (state_q == HDR1_WAIT) || (state_q == LOAD);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef IMAGE_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = '0;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    if (busy_w)
      gap_d = bus.rx_valid ? '0 : gap_q + GAP_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.rx_valid && bus.rx_data == HDR0)
          state_d = HDR1_WAIT;
      end
      HDR1_WAIT: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == HDR1) begin
            state_d = LOAD;
            cnt_d   = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            sum_d   = '0;
`endif
          end else if (bus.rx_data != HDR0) begin
            state_d = IDLE;
          end
        end
      end
      LOAD: begin
        if (bus.rx_valid) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          data_d  = bus.rx_data;
          cnt_d   = cnt_q + ADDR_W'(1);
`ifdef IMAGE_LOADER_CHECKSUM_EN
          sum_d   = sum_q + bus.rx_data;
`endif
          if (cnt_q == ADDR_W'(NUM_PIXELS - 1)) begin
            cnt_d = '0;
`ifdef IMAGE_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef IMAGE_LOADER_CHECKSUM_EN
      CHK: begin
        if (bus.rx_valid) begin
          if (bus.rx_data == sum_q) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
`endif
      DONE: begin
        // clear wins over a simultaneous byte; that byte is simply dropped
        if (bus.clear)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // timeout overrides whatever the byte in this cycle would have done
    if (busy_w && gap_q == GAP_W'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      err_d   = 1'b1;
      wr_en_d = 1'b0;
      gap_d   = '0;
    end
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_addr = addr_q;
  assign bus.ram_wr_data = data_q;
  assign bus.load_err    = err_q;
  assign bus.busy        = busy_w;
  assign bus.image_ready = (state_q == DONE);

endmodule

// File: tb/tb_image_loader.sv
// Randomized frame-level bench for image_loader with TIMEOUT_CYCLES reduced to 50.
module tb_image_loader;
  localparam int NP = 784;
  localparam int AW = 10;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_loader_if #(.ADDR_W(AW)) bus ();

  image_loader #(
    .NUM_PIXELS(NP), .ADDR_W(AW), .HDR0(8'hAA), .HDR1(8'h55), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_pix [NP];
  int         cap_addr [$];
  logic [7:0] cap_data [$];
  int         err_pulses = 0;
  logic       ready_at_last = 1'b0;
  int         r;

  // Observe the RAM port and error strobe mid-cycle
  always @(negedge clk) begin
    if (bus.ram_wr_en === 1'b1) begin
      cap_addr.push_back(int'(bus.ram_wr_addr));
      cap_data.push_back(bus.ram_wr_data);
      if (int'(bus.ram_wr_addr) == NP - 1) ready_at_last = bus.image_ready;
    end
    if (bus.load_err === 1'b1) err_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick(1);
    bus.clear = 1'b0;
  endtask

  task automatic reset_capture();
    cap_addr.delete();
    cap_data.delete();
    err_pulses    = 0;
    ready_at_last = 1'b0;
  endtask

  task automatic fill_random();
    foreach (exp_pix[i]) exp_pix[i] = 8'($urandom);
  endtask

  function automatic logic [7:0] model_sum();
    int s = 0;
    foreach (exp_pix[i]) s += int'(exp_pix[i]);
    return 8'(s % 256);
  endfunction

  // Header, npix pixels with small random gaps (one long but legal gap), then checksum if enabled
  task automatic send_frame(input int npix, input logic [7:0] sum_delta);
    send_byte(8'hAA, $urandom_range(0, 2));
    send_byte(8'h55, $urandom_range(0, 2));
    for (int i = 0; i < npix; i++)
      send_byte(exp_pix[i], (i == 400) ? 40 : $urandom_range(0, 2));
`ifdef IMAGE_LOADER_CHECKSUM_EN
    if (npix == NP) send_byte(model_sum() + sum_delta, 0);
`else
    if (sum_delta != 8'd0) tick(0);
`endif
  endtask

  // Number of captured writes deviating from "address i holds exp_pix[i]" for i < n
  function automatic int write_errs(input int n);
    int e = 0;
    if (cap_addr.size() != n) return 1000 + cap_addr.size();
    for (int i = 0; i < n; i++)
      if (cap_addr[i] != i || cap_data[i] !== exp_pix[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bus.ram_wr_en, bus.image_ready, bus.busy, bus.load_err} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000",
               {bus.ram_wr_en, bus.image_ready, bus.busy, bus.load_err});
    else n_pass++;
    n_checks++;
    if (bus.ram_wr_addr !== '0 || bus.ram_wr_data !== 8'd0)
      $display("FAIL reset_bus: got addr %0d data %0d expected 0 0", bus.ram_wr_addr, bus.ram_wr_data);
    else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_nominal();
    reset_capture();
    foreach (exp_pix[i]) exp_pix[i] = 8'(i % 256);
    send_frame(NP, 8'd0);
    tick(2);
    r = write_errs(NP);
    n_checks++;
    if (r != 0) $display("FAIL nominal_writes: got %0d bad writes expected 0", r); else n_pass++;
    n_checks++;
    if (bus.image_ready !== 1'b1) $display("FAIL nominal_ready: got %b expected 1", bus.image_ready); else n_pass++;
    n_checks++;
    if (err_pulses != 0) $display("FAIL nominal_err: got %0d pulses expected 0", err_pulses); else n_pass++;
    n_checks++;
`ifdef IMAGE_LOADER_CHECKSUM_EN
    if (ready_at_last !== 1'b0) $display("FAIL ready_with_last_write: got %b expected 0", ready_at_last); else n_pass++;
`else
    if (ready_at_last !== 1'b1) $display("FAIL ready_with_last_write: got %b expected 1", ready_at_last); else n_pass++;
`endif
  endtask

  task automatic test_hold_clear();
    reset_capture();
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    send_byte(8'hFF, 2);
    n_checks++;
    if (cap_addr.size() != 0) $display("FAIL hold_writes: got %0d writes expected 0", cap_addr.size()); else n_pass++;
    n_checks++;
    if (bus.image_ready !== 1'b1) $display("FAIL hold_ready: got %b expected 1", bus.image_ready); else n_pass++;
    bus.clear    = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hAA;
    tick(1);
    bus.clear    = 1'b0;
    bus.rx_valid = 1'b0;
    n_checks++;
    if (bus.image_ready !== 1'b0) $display("FAIL clear_ready: got %b expected 0", bus.image_ready); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL clear_drops_byte: got busy %b expected 0", bus.busy); else n_pass++;
    send_byte(8'h55, 2);
    n_checks++;
    if (bus.busy !== 1'b0 || cap_addr.size() != 0)
      $display("FAIL clear_no_load: got busy %b writes %0d expected 0 0", bus.busy, cap_addr.size());
    else n_pass++;
    fill_random();
    send_frame(NP, 8'd0);
    tick(2);
    r = write_errs(NP);
    n_checks++;
    if (r != 0 || bus.image_ready !== 1'b1)
      $display("FAIL reload_after_clear: got %0d bad writes ready %b expected 0 1", r, bus.image_ready);
    else n_pass++;
  endtask

  task automatic test_resync();
    pulse_clear();
    tick(1);
    reset_capture();
    fill_random();
    send_byte(8'h12, 0);
    send_byte(8'hAA, 1);
    send_byte(8'hAA, 0);
    send_byte(8'h07, 1);
    send_frame(NP, 8'd0);
    tick(2);
    n_checks++;
    if (cap_addr.size() == 0 || cap_addr[0] != 0 || cap_data[0] !== exp_pix[0])
      $display("FAIL resync_first: got %0d writes expected first addr 0 data %0d", cap_addr.size(), exp_pix[0]);
    else n_pass++;
    r = write_errs(NP);
    n_checks++;
    if (r != 0 || bus.image_ready !== 1'b1)
      $display("FAIL resync_frame: got %0d bad writes ready %b expected 0 1", r, bus.image_ready);
    else n_pass++;
  endtask

  task automatic test_timeout();
    pulse_clear();
    tick(1);
    reset_capture();
    fill_random();
    send_byte(8'hAA, 0);
    send_byte(8'h55, 1);
    for (int i = 0; i < 100; i++) begin
      if (i == 50) pulse_clear();
      send_byte(exp_pix[i], $urandom_range(0, 2));
    end
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL timeout_busy_before: got %b expected 1", bus.busy); else n_pass++;
    tick(TO + 10);
    n_checks++;
    if (err_pulses != 1) $display("FAIL timeout_err: got %0d pulses expected 1", err_pulses); else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.image_ready !== 1'b0)
      $display("FAIL timeout_idle: got busy %b ready %b expected 0 0", bus.busy, bus.image_ready);
    else n_pass++;
    r = write_errs(100);
    n_checks++;
    if (r != 0) $display("FAIL timeout_partial: got %0d bad writes expected 0", r); else n_pass++;
    reset_capture();
    fill_random();
    send_frame(NP, 8'd0);
    tick(2);
    r = write_errs(NP);
    n_checks++;
    if (r != 0 || bus.image_ready !== 1'b1 || err_pulses != 0)
      $display("FAIL timeout_reload: got %0d bad writes ready %b err %0d expected 0 1 0", r, bus.image_ready, err_pulses);
    else n_pass++;
  endtask

`ifdef IMAGE_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_clear();
    tick(1);
    reset_capture();
    fill_random();
    send_frame(NP, 8'd1);
    tick(3);
    n_checks++;
    if (err_pulses != 1) $display("FAIL chk_err: got %0d pulses expected 1", err_pulses); else n_pass++;
    n_checks++;
    if (bus.image_ready !== 1'b0) $display("FAIL chk_not_ready: got %b expected 0", bus.image_ready); else n_pass++;
    reset_capture();
    send_frame(NP, 8'd0);
    tick(2);
    n_checks++;
    if (bus.image_ready !== 1'b1 || err_pulses != 0)
      $display("FAIL chk_resend: got ready %b err %0d expected 1 0", bus.image_ready, err_pulses);
    else n_pass++;
  endtask
`endif

  task automatic test_reset_midload();
    pulse_clear();
    tick(1);
    reset_capture();
    fill_random();
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    for (int i = 0; i < 300; i++) send_byte(exp_pix[i], (i == 299) ? 0 : $urandom_range(0, 1));
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.ram_wr_en, bus.image_ready, bus.busy, bus.load_err} !== 4'b0 ||
        bus.ram_wr_addr !== '0 || bus.ram_wr_data !== 8'd0)
      $display("FAIL async_reset: got flags %b addr %0d data %0d expected all 0",
               {bus.ram_wr_en, bus.image_ready, bus.busy, bus.load_err}, bus.ram_wr_addr, bus.ram_wr_data);
    else n_pass++;
    tick(2);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (err_pulses != 0) $display("FAIL reset_no_err: got %0d pulses expected 0", err_pulses); else n_pass++;
    reset_capture();
    fill_random();
    send_frame(NP, 8'd0);
    tick(2);
    r = write_errs(NP);
    n_checks++;
    if (r != 0 || bus.image_ready !== 1'b1)
      $display("FAIL reset_reload: got %0d bad writes ready %b expected 0 1", r, bus.image_ready);
    else n_pass++;
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'd0;
    bus.clear    = 1'b0;
    test_reset();
    test_nominal();
    test_hold_clear();
    test_resync();
    test_timeout();
`ifdef IMAGE_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
